// File: rtl/demux_collect.sv
// Collects a stream of WIDTH-bit words into SEL*WIDTH-bit frames, word 0 in the low bits.
// Optional macro DEMUX_COLLECT_FLUSH_EN adds flush/out_count for emitting partial frames.
module demux_collect #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEL   = 4,
    localparam int unsigned NSEL = (SEL > 1) ? $clog2(SEL) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [SEL*WIDTH-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NSEL-1:0]        slot
`ifdef DEMUX_COLLECT_FLUSH_EN
    ,
    input  logic                   flush,
    output logic [NSEL:0]          out_count
`endif
);

    logic [SEL*WIDTH-1:0] acc_q, acc_d;
    logic [SEL*WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic [NSEL-1:0]      slot_q, slot_d;
    logic [NSEL:0]        count_q, count_d;

    logic                 accept, last, take, emit, flush_fire;
    logic [SEL*WIDTH-1:0] frame;

    assign last     = (slot_q == NSEL'(SEL - 1));
    assign in_ready = !last || !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign take     = out_valid_q && out_ready;

`ifdef DEMUX_COLLECT_FLUSH_EN
    assign flush_fire = flush && ((slot_q != '0) || accept) && (!out_valid_q || out_ready);
    assign out_count  = count_q;
`else
    assign flush_fire = 1'b0;
`endif

    assign emit = (accept && last) || flush_fire;

    // Unfilled slots of the accumulator are always zero, so a partial frame needs no masking.
    always_comb begin
        frame = acc_q;
        if (accept) begin
            for (int k = 0; k < SEL; k++) begin
                if (slot_q == NSEL'(k)) frame[k*WIDTH +: WIDTH] = in_data;
            end
        end
    end

    always_comb begin
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        slot_d      = slot_q;
        count_d     = count_q;
        if (emit) begin
            out_data_d  = frame;
            out_valid_d = 1'b1;
            slot_d      = '0;
            acc_d       = '0;
            count_d     = {1'b0, slot_q} + {{NSEL{1'b0}}, accept};
        end else begin
            if (accept) begin
                acc_d  = frame;
                slot_d = slot_q + 1'b1;
            end
            if (take) out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            slot_q      <= '0;
            count_q     <= '0;
        end else begin
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            slot_q      <= slot_d;
            count_q     <= count_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign slot      = slot_q;

`ifndef DEMUX_COLLECT_FLUSH_EN
    logic unused_count;
    assign unused_count = ^count_q;
`endif

endmodule

// File: tb/tb_demux_collect.sv
// Directed bench for demux_collect: WIDTH=8/SEL=4 and WIDTH=4/SEL=3 instances.
module tb_demux_collect;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [7:0]  in_data;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] out_data;
    logic [1:0]  slot;

    logic [3:0]  in_data3;
    logic        in_valid3, in_ready3, out_valid3, out_ready3;
    logic [11:0] out_data3;
    logic [1:0]  slot3;

    int checks   = 0;
    int failures = 0;

`ifdef DEMUX_COLLECT_FLUSH_EN
    logic       flush, flush3;
    logic [2:0] out_count, out_count3;
`endif

    always #5 clk = ~clk;

    demux_collect #(.WIDTH(8), .SEL(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .slot      (slot)
`ifdef DEMUX_COLLECT_FLUSH_EN
        ,
        .flush     (flush),
        .out_count (out_count)
`endif
    );

    demux_collect #(.WIDTH(4), .SEL(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .slot      (slot3)
`ifdef DEMUX_COLLECT_FLUSH_EN
        ,
        .flush     (flush3),
        .out_count (out_count3)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] w32;
        rst_n      = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        in_data3   = '0;
        in_valid3  = 1'b0;
        out_ready3 = 1'b1;
`ifdef DEMUX_COLLECT_FLUSH_EN
        flush  = 1'b0;
        flush3 = 1'b0;
`endif
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_slot", 64'(slot), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic frame 0x44332211
        w32 = 32'h44332211;
        for (int i = 0; i < 4; i++) begin
            in_data  = w32[i*8 +: 8];
            in_valid = 1'b1;
            #1;
            chk("t1_in_ready", 64'(in_ready), 64'd1);
            tick();
        end
        in_valid = 1'b0;
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_data", 64'(out_data), 64'h44332211);
        chk("t1_slot", 64'(slot), 64'd0);
`ifdef DEMUX_COLLECT_FLUSH_EN
        chk("t1_out_count", 64'(out_count), 64'd4);
`endif
        tick();
        chk("t1_valid_drop", 64'(out_valid), 64'd0);
        chk("t1_data_hold", 64'(out_data), 64'h44332211);

        // Back-to-back 0x01..0x08, out_valid after words 4 and 8 only
        for (int i = 1; i <= 8; i++) begin
            in_data  = 8'(i);
            in_valid = 1'b1;
            #1;
            chk("t2_in_ready", 64'(in_ready), 64'd1);
            tick();
            chk("t2_out_valid", 64'(out_valid), (i == 4 || i == 8) ? 64'd1 : 64'd0);
            if (i == 4) chk("t2_frame0", 64'(out_data), 64'h04030201);
        end
        in_valid = 1'b0;
        chk("t2_frame1", 64'(out_data), 64'h08070605);
        tick();
        chk("t2_valid_drop", 64'(out_valid), 64'd0);

        // Backpressure: hold frame 0x40302010, keep filling, stall on the completing word
        out_ready = 1'b0;
        w32 = 32'h40302010;
        for (int i = 0; i < 4; i++) begin
            in_data  = w32[i*8 +: 8];
            in_valid = 1'b1;
            tick();
        end
        chk("t3_held_valid", 64'(out_valid), 64'd1);
        chk("t3_held_data", 64'(out_data), 64'h40302010);
        for (int i = 0; i < 3; i++) begin
            in_data = 8'hA0 + 8'(i);
            #1;
            chk("t3_fill_ready", 64'(in_ready), 64'd1);
            tick();
            chk("t3_hold_data", 64'(out_data), 64'h40302010);
        end
        in_data = 8'hA3;
        #1;
        chk("t3_stall_ready", 64'(in_ready), 64'd0);
        chk("t3_stall_slot", 64'(slot), 64'd3);
        tick();
        chk("t3_stall_slot2", 64'(slot), 64'd3);
        chk("t3_stall_data", 64'(out_data), 64'h40302010);
        out_ready = 1'b1;
        #1;
        chk("t3_release_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("t3_new_valid", 64'(out_valid), 64'd1);
        chk("t3_new_data", 64'(out_data), 64'hA3A2A1A0);
        chk("t3_new_slot", 64'(slot), 64'd0);
        tick();
        chk("t3_valid_drop", 64'(out_valid), 64'd0);

        // SEL=3, WIDTH=4: slot wraps 0,1,2,0
        for (int i = 1; i <= 6; i++) begin
            in_data3  = 4'(i);
            in_valid3 = 1'b1;
            #1;
            chk("t4_slot", 64'(slot3), 64'((i - 1) % 3));
            tick();
            if (i == 3) begin
                chk("t4_frame0_valid", 64'(out_valid3), 64'd1);
                chk("t4_frame0", 64'(out_data3), 64'h321);
            end
        end
        in_valid3 = 1'b0;
        chk("t4_frame1_valid", 64'(out_valid3), 64'd1);
        chk("t4_frame1", 64'(out_data3), 64'h654);
        chk("t4_slot_end", 64'(slot3), 64'd0);

        // Reset mid-frame
        in_data  = 8'h99;
        in_valid = 1'b1;
        tick();
        in_data  = 8'hAA;
        tick();
        in_valid = 1'b0;
        chk("t5_pre_slot", 64'(slot), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_slot", 64'(slot), 64'd0);
        chk("t5_rst_data", 64'(out_data), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        w32 = 32'h88776655;
        for (int i = 0; i < 4; i++) begin
            in_data  = w32[i*8 +: 8];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("t5_valid", 64'(out_valid), 64'd1);
        chk("t5_data", 64'(out_data), 64'h88776655);
        tick();

`ifdef DEMUX_COLLECT_FLUSH_EN
        // Flush a partial frame, then flush with nothing buffered
        in_data  = 8'h11;
        in_valid = 1'b1;
        tick();
        in_data  = 8'h22;
        tick();
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        chk("t6_flush_valid", 64'(out_valid), 64'd1);
        chk("t6_flush_data", 64'(out_data), 64'h00002211);
        chk("t6_flush_count", 64'(out_count), 64'd2);
        chk("t6_flush_slot", 64'(slot), 64'd0);
        tick();
        flush = 1'b0;
        chk("t6_idle_flush", 64'(out_valid), 64'd0);
        chk("t6_idle_count", 64'(out_count), 64'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_collect.md
Name: demux_collect

Overview:
- Inverse of the word-select mux: gathers a stream of WIDTH-bit words into one SEL*WIDTH-bit frame.
- Slot order: word 0 goes in bits [WIDTH-1:0], word k in bits [(k+1)*WIDTH-1:k*WIDTH].
- Used wherever narrow per-cycle samples or register reads must be presented to a wide consumer (e.g. a wide CPU/SPI readback bus).
- Valid/ready handshake on both sides; one clock domain.

Parameters:
- WIDTH, "required": bits per input word, ≥1.
- SEL, "required": words per frame, ≥1, any integer (not restricted to a power of 2).
- NSEL, localparam clog2(SEL), forced ≥1: slot counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  WIDTH  input word.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  SEL*WIDTH  assembled frame; stable while out_valid=1.
- out_valid  out  1  frame available.
- out_ready  in  1  consumer takes the frame this cycle.
- slot  out  NSEL  index of the next slot to be written.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, slot=0, accumulator=0. in_ready follows from its equation, so it is 1 after reset.
- Input accept: in_valid && in_ready.
- Output take: out_valid && out_ready.
- in_ready = (slot != SEL-1) || !out_valid || out_ready, combinational. The accumulator keeps filling while a previous frame is held. Only the frame-completing word stalls.
- Accept with slot < SEL-1:
  - accumulator slot `slot` <= in_data.
  - slot <= slot+1.
- Accept with slot == SEL-1:
  - out_data <= {in_data, accumulator slots SEL-2..0}.
  - out_valid <= 1; slot <= 0; accumulator cleared to 0.
- Take with no completing accept: out_valid <= 0. out_data holds its last value.
- Take and completing accept in the same cycle: new frame loads and out_valid stays 1. This sustains 1 word/cycle throughput.
- Latency: out_valid rises the cycle after the last word is accepted.
- SEL=1: every accepted word is a frame; slot stays 0.
- Non-power-of-2 SEL: slot wraps from SEL-1 to 0, never reaches SEL.
- in_valid with in_ready=0: no state change. The source must hold in_data.
- out_data must not change while out_valid=1 and out_ready=0.
- Reset mid-frame: partial accumulator discarded, any pending frame dropped.

Optional Feature:
- Macro: DEMUX_COLLECT_FLUSH_EN.
- With the macro, two ports are added:
  - flush (in, 1): request to emit a partial frame.
  - out_count (out, NSEL+1): number of valid words in out_data, reset 0.
- Flush emits a frame when all of these hold: flush=1, (slot>0 or completing accept), output register free (!out_valid || out_ready).
  - Emitted frame: unfilled slots are zero; out_count = words in frame; slot <= 0.
- flush with an accept in the same cycle: the word is included before the frame is emitted.
- flush with slot=0 and no accept: ignored.
- flush while the output register is blocked: ignored (not queued); the source re-asserts.
- Full frames report out_count=SEL.
- Without the macro: flush and out_count are absent; behaviour is exactly as above.

Test Plan:
- WIDTH=8, SEL=4, out_ready=1, words 0x11,0x22,0x33,0x44 back-to-back -> one cycle after 0x44: out_valid=1, out_data=0x44332211 for 1 cycle; slot=0.
- Same config, 8 back-to-back words 0x01..0x08, out_ready=1 -> frames 0x04030201 then 0x08070605; in_ready never drops; out_valid high exactly cycles 5 and 9.
- Backpressure: out_ready=0 after first frame, feed 0xA0..0xA3 -> 0xA0..0xA2 accepted; in_ready=0 at slot=3; out_data held at first frame. Raise out_ready -> 0xA3 accepted same cycle; next frame 0xA3A2A1A0.
- SEL=3, WIDTH=4, feed 0x1..0x6 -> frames 0x321, 0x654; slot sequence 0,1,2,0,1,2,0.
- Assert rst_n=0 after 2 of 4 words, release, feed 0x55,0x66,0x77,0x88 -> out_data=0x88776655, no stale bytes; out_valid=0 during reset.
- With DEMUX_COLLECT_FLUSH_EN: feed 0x11,0x22, flush=1 -> out_data=0x00002211, out_count=2; flush at slot=0 -> no frame.
